// File: rtl/pkt_assembler_mc_pkg.sv
// Shared packet layout, header bit positions and parity helper for the
// multi-channel multicast packet assembler.
package pkt_assembler_pkg;

  localparam int PACKET_BITS    = 72;
  localparam int HDR_PARITY_BIT = 0;
  localparam int HDR_PLD_BIT    = 1;
  localparam int KEY_LSB        = 8;
  localparam int PLD_LSB        = 40;

  typedef struct packed {
    logic [31:0] pld;
    logic [31:0] key;
    logic [7:0]  hdr;
  } pkt_t;

  // Parity bit that gives the whole 72-bit packet odd population; hdr[0] is ignored.
  function automatic logic pkt_parity(input pkt_t p);
    return ~(^p.key ^ ^p.pld ^ ^p.hdr[7:1]);
  endfunction

endpackage

// File: rtl/pkt_assembler_mc_if.sv
// Event-in / packet-out handshake bundle for pkt_assembler_mc.
interface pkt_assembler_mc_if
  import pkt_assembler_pkg::*;
#(
  parameter int NUM_CHANNELS = 4
) ();

  logic [NUM_CHANNELS-1:0][31:0] evt_data_in;
  logic [NUM_CHANNELS-1:0]       evt_vld_in;
  logic [NUM_CHANNELS-1:0]       evt_rdy_out;
  logic [PACKET_BITS-1:0]        pkt_data_out;
  logic                          pkt_vld_out;
  logic                          pkt_rdy_in;

  modport slave (
    input  evt_data_in, evt_vld_in, pkt_rdy_in,
    output evt_rdy_out, pkt_data_out, pkt_vld_out
  );

  modport master (
    output evt_data_in, evt_vld_in, pkt_rdy_in,
    input  evt_rdy_out, pkt_data_out, pkt_vld_out
  );

endinterface

// File: rtl/pkt_assembler_mc_fifo.sv
// Synchronous valid/ready FIFO; the head is presented straight from storage
// registers, and a push into a full FIFO is accepted when a pop happens too.
module pkt_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;

  assign out_vld  = (count_q != '0);
  assign out_data = mem_q[rd_ptr_q];
  assign pop      = out_vld && out_rdy;
  assign in_rdy   = (count_q != (AW+1)'(DEPTH)) || out_rdy;
  assign push     = in_vld && in_rdy;

  // NOTE: non-blocking assignments in clocked blocks keep every register
  // sampling pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: storage is reset so the head word reads 0 out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pkt_assembler_mc.sv
// Multi-channel event-to-packet assembler: per-channel holding registers,
// round-robin arbiter, key mapper, output FIFO. Optional macro PKT_ASSEMBLER_TSTAMP_EN.
module pkt_assembler_mc
  import pkt_assembler_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_MREGS    = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_CHANNELS-1:0][31:0]          mp_key_in,
  input  logic [NUM_CHANNELS*NUM_MREGS-1:0][31:0] field_msk_in,
  input  logic [NUM_CHANNELS*NUM_MREGS-1:0][4:0]  field_sft_in,
  pkt_assembler_mc_if.slave                      bus,
  output logic [31:0]                            pkt_cnt_out
);

  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0][31:0] hold_data_q;
  logic [NUM_CHANNELS-1:0]       full_q, grant, accept;
  logic [CH_W-1:0]               ptr_q, gnt_idx;
  logic                          gnt_vld, push, fifo_in_rdy;
  logic [31:0]                   key;
  pkt_t                          pkt;

  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] p, input int off);
    return CH_W'((int'(p) + off) % NUM_CHANNELS);
  endfunction

  // Walk from farthest to nearest so the channel right after the pointer wins.
  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    for (int i = NUM_CHANNELS; i >= 1; i--) begin
      if (full_q[rr_idx(ptr_q, i)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx(ptr_q, i);
      end
    end
  end

  assign push = gnt_vld && fifo_in_rdy;

  always_comb begin
    grant = '0;
    if (push) grant[gnt_idx] = 1'b1;
  end

  assign bus.evt_rdy_out = ~full_q | grant;
  assign accept          = bus.evt_vld_in & bus.evt_rdy_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q      <= '0;
      hold_data_q <= '0;
      ptr_q       <= CH_W'(NUM_CHANNELS - 1);
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (accept[c]) begin
          full_q[c]      <= 1'b1;
          hold_data_q[c] <= bus.evt_data_in[c];
        end else if (grant[c]) begin
          full_q[c] <= 1'b0;
        end
      end
      if (push) ptr_q <= gnt_idx;
    end
  end

`ifdef PKT_ASSEMBLER_TSTAMP_EN
  logic [31:0]                   tstamp_q;
  logic [NUM_CHANNELS-1:0][31:0] hold_ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tstamp_q  <= '0;
      hold_ts_q <= '0;
    end else begin
      tstamp_q <= tstamp_q + 32'd1;
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (accept[c]) hold_ts_q[c] <= tstamp_q;
    end
  end
`endif

  always_comb begin
    key = mp_key_in[gnt_idx];
    for (int m = 0; m < NUM_MREGS; m++)
      key = key | ((hold_data_q[gnt_idx] & field_msk_in[int'(gnt_idx)*NUM_MREGS + m])
                   >> field_sft_in[int'(gnt_idx)*NUM_MREGS + m]);
    pkt     = '0;
    pkt.key = key;
`ifdef PKT_ASSEMBLER_TSTAMP_EN
    pkt.pld              = hold_ts_q[gnt_idx];
    pkt.hdr[HDR_PLD_BIT] = 1'b1;
`endif
    pkt.hdr[HDR_PARITY_BIT] = pkt_parity(pkt);
  end

  pkt_fifo #(
    .WIDTH (PACKET_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (pkt),
    .in_vld   (gnt_vld),
    .in_rdy   (fifo_in_rdy),
    .out_data (bus.pkt_data_out),
    .out_vld  (bus.pkt_vld_out),
    .out_rdy  (bus.pkt_rdy_in)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pkt_cnt_out <= '0;
    else if (bus.pkt_vld_out && bus.pkt_rdy_in) pkt_cnt_out <= pkt_cnt_out + 32'd1;
  end

endmodule

// File: doc/pkt_assembler_mc.md
Name: pkt_assembler_mc

Overview:
- Multi-channel successor to the single-channel multicast packet assembler.
- Accepts events from NUM_CHANNELS independent event sources, each with its own key and field-mapping config.
- Maps each event to a 32-bit routing key, arbitrates round-robin among channels, and queues packets in a FIFO_DEPTH-entry output FIFO.
- Sits between the event front-ends and the SpiNNaker link transmitter.

Parameters:
- PACKET_BITS, 72, packet width {pld[31:0], key[31:0], hdr[7:0]}; fixed at 72.
- NUM_CHANNELS, 4, number of event input channels (1..8).
- NUM_MREGS, 4, field mask/shift registers per channel (1..8).
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- mp_key_in  in  [NUM_CHANNELS] x 32  per-channel mapping base key
- field_msk_in  in  [NUM_CHANNELS*NUM_MREGS] x 32  field masks; index c*NUM_MREGS+m
- field_sft_in  in  [NUM_CHANNELS*NUM_MREGS] x 5  right-shift amounts, same indexing
- evt_data_in  in  [NUM_CHANNELS] x 32  event data
- evt_vld_in  in  NUM_CHANNELS  event valid, one bit per channel
- evt_rdy_out  out  NUM_CHANNELS  event ready, one bit per channel
- pkt_data_out  out  PACKET_BITS  packet
- pkt_vld_out  out  1  packet valid
- pkt_rdy_in  in  1  packet ready
- pkt_cnt_out  out  32  packets emitted since reset; wraps

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. Reset clears all state.
- Reset values: evt_rdy_out = all 1s, pkt_vld_out = 0, pkt_data_out = 0, pkt_cnt_out = 0, FIFO empty, channel holding registers empty, RR pointer = NUM_CHANNELS-1 (channel 0 has first priority).
- Per-channel holding register: one data word plus a full flag.
  - Accept when evt_vld_in[c] && evt_rdy_out[c].
  - evt_rdy_out[c] = !full[c] || grant[c] (combinational; grant does not depend on evt_vld_in, so no loop).
  - Result: one event per cycle per channel, sustained.
- Arbiter: round-robin.
  - Candidates: channels with full[c]. A grant is issued only when the FIFO is not full (or is being popped in the same cycle).
  - Search starts at pointer+1; the pointer loads the granted index.
  - At most one grant per cycle.
- Mapping: combinational on the granted channel's held data d.
  - key = mp_key[g] | OR over m of ((d & msk[g][m]) >> sft[g][m]).
  - Logical shift, 0..31; bits shifted out are lost.
- Header:
  - hdr[7:2] = 0.
  - hdr[1] = payload-present flag.
  - hdr[0] = odd parity: ~(^key ^ ^pld ^ ^hdr[7:1]). The full 72-bit packet must have odd population.
- FIFO: the granted packet is written in the grant cycle.
  - pkt_data_out and pkt_vld_out come from the FIFO head and are registered.
  - Simultaneous push/pop when full is allowed.
  - Latency: event accepted in cycle N → pkt_vld_out in cycle N+2 (empty FIFO, uncontended channel).
- Output handshake: pkt_data_out must be stable while pkt_vld_out && !pkt_rdy_in.
  - pkt_cnt_out increments on each pkt_vld_out && pkt_rdy_in; wraps 0xFFFF_FFFF → 0.
- No-loss rule: back-pressure propagates to evt_rdy_out; no event is ever dropped or duplicated.
- Order:
  - Per-channel order is preserved.
  - Inter-channel order is set by the arbitration sequence.
- Reset mid-operation: all queued events and packets are discarded immediately. Outputs take reset values asynchronously.

Optional Feature:
- Macro PKT_ASSEMBLER_TSTAMP_EN.
- Defined:
  - A free-running 32-bit timestamp counter (reset 0, +1 per clk, wraps).
  - Its value is captured into the channel holding register at event acceptance.
  - It becomes pld, and hdr[1] = 1.
- Undefined:
  - pld = 0, hdr[1] = 0.
  - No counter or holding storage for it is synthesised.
  - Parity is computed identically in both cases.

Decomposition:
- Package pkt_assembler_pkg:
  - HDR_PARITY_BIT = 0, HDR_PLD_BIT = 1, KEY_LSB = 8, PLD_LSB = 40.
  - Typedef pkt_t (72-bit packed struct pld/key/hdr).
  - Function pkt_parity().
- Sub-module pkt_fifo: parametrised synchronous FIFO with registered outputs and valid/ready.
- Arbiter and mapper stay inline.

Test Plan:
- Single channel 0: mp_key = 0x1200_0000, msk0 = 0x0000_FF00, sft0 = 8, other masks 0; event 0x0000_AB00 → key 0x1200_00AB at cycle N+2, hdr = 0x00, odd parity over 72 bits.
- All 4 channels valid every cycle, pkt_rdy_in = 1 → grants in order 0,1,2,3,0,...; each channel averages 1 packet per 4 cycles; no evt_rdy_out glitch loss.
- Hold pkt_rdy_in = 0 for 20 cycles with channel 1 streaming → exactly FIFO_DEPTH+1 events accepted, then evt_rdy_out[1] = 0; pkt_data_out stable; release → all packets emitted in order.
- Shift boundaries: msk = 0xFFFF_FFFF, sft = 31, event 0x8000_0000 → key bit0 = 1; sft = 0 → passthrough OR with mp_key.
- reset_n asserted while FIFO holds 3 packets → pkt_vld_out = 0 immediately, pkt_cnt_out = 0; after release, the first packet comes from channel 0 if all channels are valid.
- With PKT_ASSEMBLER_TSTAMP_EN: event accepted at timestamp 0x0000_0005 → pld = 0x0000_0005, hdr[1] = 1, parity correct; without the macro, pld = 0 and hdr[1] = 0.
